// File: rtl/weight_slot_sequencer.sv
// Registered valid/ready weight-slice sequencer: presents one WIDTH-bit slice of
// a flat NUM_SLOTS-slice bus per transfer, either a single indexed slice or a full sweep.
module weight_slot_sequencer #(
  parameter int WIDTH     = 532,
  parameter int NUM_SLOTS = 28,
  parameter int SEL_BITS  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH*NUM_SLOTS-1:0] In,
  input  logic                       Start,
  input  logic                       Mode,
  input  logic [SEL_BITS-1:0]        Select,
  input  logic                       Abort,
  input  logic                       OutReady,
  output logic [WIDTH-1:0]           Out,
  output logic                       OutValid,
  output logic [SEL_BITS-1:0]        OutIndex,
  output logic                       Busy,
  output logic                       Done,
  output logic                       SelErr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SWEEP
  } state_t;

  localparam logic [SEL_BITS-1:0] LAST_IDX   = SEL_BITS'(NUM_SLOTS - 1);
  localparam logic [SEL_BITS:0]   SLOT_COUNT = (SEL_BITS + 1)'(NUM_SLOTS);

  if ((2 ** SEL_BITS) < NUM_SLOTS) begin : g_bad_sel_bits
    $error("SEL_BITS too narrow to index NUM_SLOTS slices");
  end

  // Unpack the flat bus once so the load mux is a plain array index.
  logic [WIDTH-1:0] slots [NUM_SLOTS];

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slots
    assign slots[k] = In[WIDTH*k +: WIDTH];
  end

  state_t              state, state_next;
  logic                load;
  logic [SEL_BITS-1:0] load_idx;
  logic                valid_next;
  logic                done_next;
  logic                sel_err_next;
  logic                accept;

  assign accept = OutValid & OutReady;
  assign Busy   = (state != ST_IDLE);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    state_next   = state;
    load         = 1'b0;
    load_idx     = '0;
    valid_next   = OutValid;
    done_next    = 1'b0;
    sel_err_next = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // Abort in the same cycle drops the request.
        if (Start && !Abort) begin
          load       = 1'b1;
          valid_next = 1'b1;
          if (Mode) begin
            state_next = ST_SWEEP;
          end else begin
            state_next = ST_DIRECT;
            if ({1'b0, Select} >= SLOT_COUNT) begin
              sel_err_next = 1'b1;
            end else begin
              load_idx = Select;
            end
          end
        end
      end

      ST_DIRECT: begin
        if (Abort) begin
          state_next = ST_IDLE;
          valid_next = 1'b0;
        end else if (accept) begin
          state_next = ST_IDLE;
          valid_next = 1'b0;
          done_next  = 1'b1;
        end
      end

      ST_SWEEP: begin
        if (Abort) begin
          state_next = ST_IDLE;
          valid_next = 1'b0;
        end else if (accept) begin
          if (OutIndex == LAST_IDX) begin
            state_next = ST_IDLE;
            valid_next = 1'b0;
            done_next  = 1'b1;
          end else begin
            // Reload on the accepting edge keeps OutValid high with no bubble.
            load     = 1'b1;
            load_idx = OutIndex + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  // NOTE: the wide Out register is reset too, because consumers see Out=0
  // straight out of reset; it is not a memory array, so the reset is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      Out      <= '0;
      OutValid <= 1'b0;
      OutIndex <= '0;
      Done     <= 1'b0;
      SelErr   <= 1'b0;
    end else begin
      state    <= state_next;
      OutValid <= valid_next;
      Done     <= done_next;
      SelErr   <= sel_err_next;
      if (load) begin
        Out      <= slots[load_idx];
        OutIndex <= load_idx;
      end
    end
  end

endmodule

// File: tb/tb_weight_slot_sequencer.sv
// Scoreboard bench for weight_slot_sequencer: stimulus queues expected slices,
// a negedge monitor pops and compares on every accept and watches Done/SelErr/hold/gap rules.
module tb_weight_slot_sequencer;

  localparam int WIDTH     = 532;
  localparam int NUM_SLOTS = 28;
  localparam int SEL_BITS  = 5;

  typedef struct {
    logic [WIDTH-1:0]    data;
    logic [SEL_BITS-1:0] idx;
    logic                sel_err;
    logic                last;
  } exp_t;

  logic                       clk;
  logic                       rst_n;
  logic [WIDTH*NUM_SLOTS-1:0] in_bus;
  logic                       start;
  logic                       mode;
  logic [SEL_BITS-1:0]        sel;
  logic                       abort;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic                       out_valid;
  logic [SEL_BITS-1:0]        out_index;
  logic                       busy;
  logic                       done;
  logic                       sel_err;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  weight_slot_sequencer #(
    .WIDTH    (WIDTH),
    .NUM_SLOTS(NUM_SLOTS),
    .SEL_BITS (SEL_BITS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .In      (in_bus),
    .Start   (start),
    .Mode    (mode),
    .Select  (sel),
    .Abort   (abort),
    .OutReady(out_ready),
    .Out     (out_data),
    .OutValid(out_valid),
    .OutIndex(out_index),
    .Busy    (busy),
    .Done    (done),
    .SelErr  (sel_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [WIDTH-1:0] pat(int k, int seed);
    logic [WIDTH+31:0] v;
    v = '0;
    for (int w = 0; w * 32 < WIDTH; w++)
      v[w*32 +: 32] = (32'(seed) * 32'h0100_0193) ^ (32'(k) << 20) ^ 32'(w * 7 + 1);
    return v[WIDTH-1:0];
  endfunction

  task automatic load_bus(int seed, bit invert);
    for (int k = 0; k < NUM_SLOTS; k++)
      in_bus[k*WIDTH +: WIDTH] = invert ? ~pat(k, seed) : pat(k, seed);
  endtask

  task automatic check(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(int k, int seed, bit se, bit last);
    exp_t e;
    e.data    = pat(k, seed);
    e.idx     = SEL_BITS'(k);
    e.sel_err = se;
    e.last    = last;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep(int count, int seed);
    for (int k = 0; k < count; k++) push(k, seed, 1'b0, k == NUM_SLOTS - 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(bit m, logic [SEL_BITS-1:0] s);
    start = 1'b1;
    mode  = m;
    sel   = s;
    step();
    start = 1'b0;
  endtask

  // Monitor state.
  logic                prev_valid, prev_ready, prev_abort, prev_acc_nonlast, done_due, acc;
  logic [WIDTH-1:0]    prev_out;
  logic [SEL_BITS-1:0] prev_idx;
  exp_t                mon_e;

  initial begin
    prev_valid = 0; prev_ready = 0; prev_abort = 0; prev_acc_nonlast = 0; done_due = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid       = 1'b0;
      prev_ready       = 1'b0;
      prev_abort       = 1'b0;
      prev_acc_nonlast = 1'b0;
      done_due         = 1'b0;
    end else begin
      acc = out_valid && out_ready && !abort;
      if (done_due) begin
        check("done_pulse", done, 1);
        done_due = 1'b0;
      end else if (done) begin
        check("done_spurious", done, 0);
      end
      if (prev_valid && !prev_ready && !prev_abort) begin
        check("hold_valid", out_valid, 1);
        check("hold_out", out_data, prev_out);
        check("hold_idx", out_index, prev_idx);
      end
      if (prev_acc_nonlast && !out_valid && exp_q.size() > 0)
        check("no_bubble", out_valid, 1);
      if (acc) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_accept: index %0d with nothing expected", out_index);
          prev_acc_nonlast = 1'b0;
        end else begin
          mon_e = exp_q.pop_front();
          check("accept_data", out_data, mon_e.data);
          check("accept_idx", out_index, mon_e.idx);
          check("accept_selerr", sel_err, mon_e.sel_err);
          done_due         = mon_e.last;
          prev_acc_nonlast = !mon_e.last;
        end
      end else begin
        prev_acc_nonlast = 1'b0;
        if (sel_err) check("selerr_spurious", sel_err, 0);
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_abort = abort;
      prev_out   = out_data;
      prev_idx   = out_index;
    end
  end

  task automatic check_zero_outputs(string tag);
    check({tag, "_out"}, out_data, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_index"}, out_index, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_selerr"}, sel_err, 0);
  endtask

  logic [15:0] rdy_pat = 16'b1011_0010_1110_0110;

  initial begin
    int acc_cnt;
    int cyc;
    bit r;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; sel = '0; abort = 1'b0; out_ready = 1'b0;
    load_bus(1, 1'b0);
    repeat (2) step();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    step();

    // Direct Select=5, then Start in the Done cycle for Select=27.
    out_ready = 1'b1;
    push(5, 1, 1'b0, 1'b1);
    start_op(1'b0, 5'd5);
    check("direct_busy_high", busy, 1);
    step();
    check("direct_busy_low", busy, 0);
    check("direct_valid_low", out_valid, 0);
    push(27, 1, 1'b0, 1'b1);
    start_op(1'b0, 5'd27);
    check("done_cycle_start_busy", busy, 1);
    step();
    step();

    // Out-of-range select falls back to slot 0 with SelErr.
    push(0, 1, 1'b1, 1'b1);
    start_op(1'b0, 5'd30);
    step();
    step();

    // Full-rate sweep.
    load_bus(2, 1'b0);
    push_sweep(NUM_SLOTS, 2);
    start_op(1'b1, '0);
    repeat (NUM_SLOTS) step();
    check("sweep_busy_low", busy, 0);
    step();

    // Stalled sweep with In scrambled during stalls and a Start while busy.
    load_bus(3, 1'b0);
    push_sweep(NUM_SLOTS, 3);
    start_op(1'b1, '0);
    acc_cnt = 0;
    cyc     = 0;
    while (acc_cnt < NUM_SLOTS) begin
      r         = rdy_pat[cyc % 16];
      out_ready = r;
      load_bus(3, !r);
      if (cyc == 4) begin
        start = 1'b1; mode = 1'b0; sel = 5'd3;
      end
      step();
      start = 1'b0;
      if (r) acc_cnt++;
      cyc++;
    end
    load_bus(3, 1'b0);
    out_ready = 1'b1;
    check("stall_busy_low", busy, 0);
    step();

    // Abort at index 10 alongside OutReady=1.
    load_bus(4, 1'b0);
    push_sweep(10, 4);
    start_op(1'b1, '0);
    repeat (10) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_keep_idx", out_index, 10);
    check("abort_keep_out", out_data, pat(10, 4));
    abort = 1'b1; start = 1'b1; mode = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    check("abort_start_valid", out_valid, 0);
    check("abort_start_busy", busy, 0);
    push_sweep(NUM_SLOTS, 4);
    start_op(1'b1, '0);
    repeat (NUM_SLOTS) step();
    step();

    // Asynchronous reset at index 15, then a clean sweep.
    load_bus(5, 1'b0);
    push_sweep(15, 5);
    start_op(1'b1, '0);
    repeat (15) step();
    #1 rst_n = 1'b0;
    #1 check_zero_outputs("async_reset");
    #1 rst_n = 1'b1;
    step();
    push_sweep(NUM_SLOTS, 5);
    start_op(1'b1, '0);
    repeat (NUM_SLOTS) step();
    check("post_reset_busy_low", busy, 0);
    repeat (3) step();

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
